// File: rtl/inst_fetch_pkg.sv
//------------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch FSM state encoding
//   - default I-cache index width and the matching tag-width helper
//   - instruction-word constants (canonical NOP, all-zero word)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package inst_fetch_pkg;

    // IDLE    : lookup / deliver on hit, issue a request on miss
    // FETCH   : memory transaction outstanding, its word will be used
    // DISCARD : memory transaction outstanding, but a redirect made it stale
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    // log2 of the number of single-word cache lines
    localparam int IC_IDX_W = 6;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Tag covers everything above the line index and the 2-bit byte offset.
    function automatic int ic_tag_w(input int idx_w);
        return 32 - idx_w - 2;
    endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
//------------------------------------------------------------------------------
// inst_fetch_icache
// Direct-mapped instruction cache storage, one 32-bit word per line.
//   i_clk       : clock
//   i_rst       : synchronous active-high, clears every valid bit
//   i_wr_en     : write the line at i_wr_idx (data, tag, valid) on this edge
//   i_wr_idx    : line index to fill
//   i_wr_tag    : tag stored with the line
//   i_wr_data   : instruction word stored in the line
//   i_rd_idx    : lookup index (combinational read)
//   o_rd_valid  : valid bit of the addressed line
//   o_rd_tag    : stored tag of the addressed line
//   o_rd_data   : stored word of the addressed line
// A write and a read of the same index in one cycle return the old contents,
// because the write only lands on the clock edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module inst_fetch_icache
    import inst_fetch_pkg::*;
#(
    parameter int IDX_W = IC_IDX_W,
    parameter int TAG_W = ic_tag_w(IC_IDX_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_data
);

    localparam int LINES = 1 << IDX_W;

    logic [31:0]      r_data  [LINES];
    logic [TAG_W-1:0] r_tag   [LINES];
    logic [LINES-1:0] r_valid;

    // Only the valid bits need a defined reset value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_data[i_wr_idx] <= i_wr_data;
            r_tag[i_wr_idx]  <= i_wr_tag;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/inst_fetch.sv
//------------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage with a direct-mapped single-word-line I-cache.
// Delivers one instruction per cycle on consecutive hits; on a miss it holds
// a request to the memory controller until the word comes back, fills the
// line and retries the lookup.
//   clk_in          : clock, rising edge
//   rst_in          : synchronous active-high reset
//   rdy_in          : global ready, low freezes all state and outputs
//   stall_in        : freeze fetch progress and IF/ID outputs
//   jump_in         : redirect from EX
//   jump_pc_in      : redirect target
//   mem_req_out     : fetch request to memory controller
//   mem_addr_out    : fetch address
//   mem_done_in     : one-cycle pulse, mem_inst_in valid
//   mem_inst_in     : fetched instruction word
//   pc_out          : PC of delivered instruction
//   inst_out        : delivered instruction
//   inst_valid_out  : pc_out/inst_out hold a real instruction
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ICACHE_IDX_W = IC_IDX_W
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        stall_in,
    input  logic        jump_in,
    input  logic [31:0] jump_pc_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_done_in,
    input  logic [31:0] mem_inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid_out
);

    localparam int TAG_W = ic_tag_w(ICACHE_IDX_W);

    // registered state and outputs
    fetch_state_t r_state;
    logic [31:0]  r_pc_q;
    logic         r_mem_req;
    logic [31:0]  r_mem_addr;
    logic [31:0]  r_pc_out;
    logic [31:0]  r_inst_out;
    logic         r_inst_valid;

    // next-state values
    fetch_state_t w_state_nxt;
    logic [31:0]  w_pc_q_nxt;
    logic         w_mem_req_nxt;
    logic [31:0]  w_mem_addr_nxt;
    logic [31:0]  w_pc_out_nxt;
    logic [31:0]  w_inst_out_nxt;
    logic         w_inst_valid_nxt;

    // cache lookup / fill
    logic [ICACHE_IDX_W-1:0] w_rd_idx;
    logic [TAG_W-1:0]        w_pc_tag;
    logic                    w_line_valid;
    logic [TAG_W-1:0]        w_line_tag;
    logic [31:0]             w_line_data;
    logic                    w_hit;
    logic                    w_fill_en;
    logic [ICACHE_IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0]        w_fill_tag;

    assign w_rd_idx   = r_pc_q[ICACHE_IDX_W+1:2];
    assign w_pc_tag   = r_pc_q[31:ICACHE_IDX_W+2];
    assign w_hit      = w_line_valid && (w_line_tag == w_pc_tag);

    // The fill always targets the outstanding request address, even after a
    // redirect: the returned word is still correct for that address.
    assign w_fill_idx = r_mem_addr[ICACHE_IDX_W+1:2];
    assign w_fill_tag = r_mem_addr[31:ICACHE_IDX_W+2];

    inst_fetch_icache #(
        .IDX_W (ICACHE_IDX_W),
        .TAG_W (TAG_W)
    ) u_icache (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_wr_en    (w_fill_en),
        .i_wr_idx   (w_fill_idx),
        .i_wr_tag   (w_fill_tag),
        .i_wr_data  (mem_inst_in),
        .i_rd_idx   (w_rd_idx),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_q_nxt       = r_pc_q;
        w_mem_req_nxt    = r_mem_req;
        w_mem_addr_nxt   = r_mem_addr;
        w_pc_out_nxt     = r_pc_out;
        w_inst_out_nxt   = r_inst_out;
        w_inst_valid_nxt = r_inst_valid;
        w_fill_en        = 1'b0;

        // With rdy_in low every register simply keeps its value.
        if (rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (jump_in) begin
                        w_pc_q_nxt       = jump_pc_in;
                        w_inst_valid_nxt = 1'b0;
                    end else if (stall_in) begin
                        // hold everything
                    end else if (w_hit) begin
                        w_pc_out_nxt     = r_pc_q;
                        w_inst_out_nxt   = w_line_data;
                        w_inst_valid_nxt = 1'b1;
                        w_pc_q_nxt       = r_pc_q + 32'd4;
                    end else begin
                        w_mem_req_nxt    = 1'b1;
                        w_mem_addr_nxt   = r_pc_q;
                        w_inst_valid_nxt = 1'b0;
                        w_state_nxt      = ST_FETCH;
                    end
                end

                ST_FETCH, ST_DISCARD: begin
                    // stall_in deliberately has no effect here: the memory
                    // transaction and the line fill always complete.
                    w_inst_valid_nxt = 1'b0;
                    if (jump_in) begin
                        w_pc_q_nxt = jump_pc_in;
                    end
                    if (mem_done_in) begin
                        w_fill_en     = 1'b1;
                        w_mem_req_nxt = 1'b0;
                        w_state_nxt   = ST_IDLE;
                    end else if (jump_in) begin
                        w_state_nxt   = ST_DISCARD;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_pc_q       <= ZERO_WORD;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= ZERO_WORD;
            r_pc_out     <= ZERO_WORD;
            r_inst_out   <= ZERO_WORD;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc_q       <= w_pc_q_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_inst_out   <= w_inst_out_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    assign mem_req_out    = r_mem_req;
    assign mem_addr_out   = r_mem_addr;
    assign pc_out         = r_pc_out;
    assign inst_out       = r_inst_out;
    assign inst_valid_out = r_inst_valid;

endmodule
